// File: rtl/switch_debouncer.sv
// -----------------------------------------------------------------------------
// switch_debouncer
//   Conditions raw slide-switch pins: a two-flop synchroniser per channel into
//   the CLK domain, then a per-channel stability counter that only accepts a
//   new level once it has been seen for CNT_MAX consecutive synchronised
//   samples. Emits a registered clean level plus one-cycle rise/fall pulses.
//
//   Optional feature (macro SW_DEBOUNCE_TOGGLE_EN): adds SW_TOGGLE, a
//   push-on/push-off latch per channel that inverts on every SW_RISE.
//
// Ports:
//   CLK        in   1       system clock, rising edge
//   RST        in   1       synchronous, active-high reset
//   SW_RAW     in   NUM_SW  raw asynchronous switch pins
//   SW_LEVEL   out  NUM_SW  debounced registered level
//   SW_RISE    out  NUM_SW  one-cycle pulse on SW_LEVEL 0->1
//   SW_FALL    out  NUM_SW  one-cycle pulse on SW_LEVEL 1->0
//   SW_TOGGLE  out  NUM_SW  (SW_DEBOUNCE_TOGGLE_EN only) toggle latch
// -----------------------------------------------------------------------------
module switch_debouncer #(
  parameter int NUM_SW      = 2,
  parameter int CLK_HZ      = 16000000,
  parameter int DEBOUNCE_US = 10000,
  parameter bit INIT_LEVEL  = 1'b0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NUM_SW-1:0] SW_RAW,
  output logic [NUM_SW-1:0] SW_LEVEL,
  output logic [NUM_SW-1:0] SW_RISE,
  output logic [NUM_SW-1:0] SW_FALL
`ifdef SW_DEBOUNCE_TOGGLE_EN
  ,
  output logic [NUM_SW-1:0] SW_TOGGLE
`endif
);

  localparam int CNT_MAX = (CLK_HZ / 1000000) * DEBOUNCE_US;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  if (CNT_MAX < 2) begin : g_cnt_max_check
    $error("switch_debouncer: CNT_MAX must be at least 2");
  end

  logic [NUM_SW-1:0] sync1;
  logic [NUM_SW-1:0] sync2;
  logic [CNT_W-1:0]  cnt [NUM_SW];

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1    <= {NUM_SW{INIT_LEVEL}};
      sync2    <= {NUM_SW{INIT_LEVEL}};
      SW_LEVEL <= {NUM_SW{INIT_LEVEL}};
      SW_RISE  <= '0;
      SW_FALL  <= '0;
      for (int unsigned i = 0; i < NUM_SW; i++) begin
        cnt[i] <= '0;
      end
`ifdef SW_DEBOUNCE_TOGGLE_EN
      SW_TOGGLE <= '0;
`endif
    end else begin
      sync1   <= SW_RAW;
      sync2   <= sync1;
      SW_RISE <= '0;
      SW_FALL <= '0;
      for (int unsigned i = 0; i < NUM_SW; i++) begin
        if (sync2[i] == SW_LEVEL[i]) begin
          // Back at (or still at) the accepted level: discard pending time.
          cnt[i] <= '0;
        end else if (cnt[i] != CNT_LAST) begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end else begin
          // New level held for CNT_MAX samples: accept it and pulse.
          cnt[i]      <= '0;
          SW_LEVEL[i] <= sync2[i];
          SW_RISE[i]  <= sync2[i];
          SW_FALL[i]  <= ~sync2[i];
`ifdef SW_DEBOUNCE_TOGGLE_EN
          if (sync2[i]) begin
            SW_TOGGLE[i] <= ~SW_TOGGLE[i];
          end
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// -----------------------------------------------------------------------------
// tb_switch_debouncer
//   Scoreboard bench for switch_debouncer (CNT_MAX = 4). The stimulus process
//   drives SW_RAW/RST, and after each edge computes the expected outputs from
//   a window rule over the recorded input history: the level flips at edge n
//   when the synchronised samples of the last CNT_MAX edges (all after the
//   previous level change or reset) all differ from the current level.
//   A monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_switch_debouncer;

  localparam int   NUM_SW  = 2;
  localparam int   CNT_MAX = 4;
  localparam int   MAXN    = 8192;
  localparam logic INIT    = 1'b0;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic [NUM_SW-1:0] SW_RAW = '1;
  logic [NUM_SW-1:0] SW_LEVEL;
  logic [NUM_SW-1:0] SW_RISE;
  logic [NUM_SW-1:0] SW_FALL;
`ifdef SW_DEBOUNCE_TOGGLE_EN
  logic [NUM_SW-1:0] SW_TOGGLE;
`endif

  always #5 CLK = ~CLK;

  switch_debouncer #(
    .NUM_SW      (NUM_SW),
    .CLK_HZ      (1000000),
    .DEBOUNCE_US (4),
    .INIT_LEVEL  (INIT)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .SW_RAW    (SW_RAW),
    .SW_LEVEL  (SW_LEVEL),
    .SW_RISE   (SW_RISE),
    .SW_FALL   (SW_FALL)
`ifdef SW_DEBOUNCE_TOGGLE_EN
    ,
    .SW_TOGGLE (SW_TOGGLE)
`endif
  );

  typedef struct packed {
    int                edge_no;
    logic [NUM_SW-1:0] lvl;
    logic [NUM_SW-1:0] rise;
    logic [NUM_SW-1:0] fall;
    logic [NUM_SW-1:0] tog;
  } exp_t;

  exp_t q[$];

  logic [NUM_SW-1:0] raw_hist [MAXN];
  logic              rst_hist [MAXN];
  int                n = 0;
  logic [NUM_SW-1:0] m_lvl = {NUM_SW{INIT}};
  logic [NUM_SW-1:0] m_tog = '0;
  int                last_evt [NUM_SW];

  int tests = 0;
  int fails = 0;

  // Synchronised value seen by the filter at edge m: the raw value sampled
  // two edges earlier, unless a reset at either of those edges intervened.
  function automatic logic [NUM_SW-1:0] s_at(input int m);
    if (m < 2) return {NUM_SW{INIT}};
    if (rst_hist[m-1] || rst_hist[m-2]) return {NUM_SW{INIT}};
    return raw_hist[m-2];
  endfunction

  task automatic step(input logic [NUM_SW-1:0] raw, input logic rst);
    exp_t              e;
    logic [NUM_SW-1:0] s;
    bit                ok;
    SW_RAW = raw;
    RST    = rst;
    @(posedge CLK);
    #1;
    if (n >= MAXN) begin
      $display("FAIL history overflow at edge %0d: got %0d entries, limit %0d", n, n, MAXN);
      $fatal(1, "history overflow");
    end
    raw_hist[n] = raw;
    rst_hist[n] = rst;
    e = '0;
    e.edge_no = n;
    if (rst) begin
      m_lvl = {NUM_SW{INIT}};
      m_tog = '0;
      for (int ch = 0; ch < NUM_SW; ch++) last_evt[ch] = n;
    end else begin
      for (int ch = 0; ch < NUM_SW; ch++) begin
        ok = (n - CNT_MAX >= last_evt[ch]);
        for (int k = 0; k < CNT_MAX; k++) begin
          s = s_at(n - k);
          if (s[ch] == m_lvl[ch]) ok = 1'b0;
        end
        if (ok) begin
          m_lvl[ch] = ~m_lvl[ch];
          if (m_lvl[ch]) begin
            e.rise[ch] = 1'b1;
            m_tog[ch]  = ~m_tog[ch];
          end else begin
            e.fall[ch] = 1'b1;
          end
          last_evt[ch] = n;
        end
      end
    end
    e.lvl = m_lvl;
    e.tog = m_tog;
    q.push_back(e);
    n++;
  endtask

  task automatic hold(input logic [NUM_SW-1:0] raw, input logic rst, input int cycles);
    for (int c = 0; c < cycles; c++) step(raw, rst);
  endtask

  // Monitor: outputs are presented every cycle; compare away from the edge.
  exp_t mon_e;
  always @(negedge CLK) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      tests++;
      if (SW_LEVEL !== mon_e.lvl) begin
        fails++;
        $display("FAIL level edge %0d: got %b expected %b", mon_e.edge_no, SW_LEVEL, mon_e.lvl);
      end
      tests++;
      if (SW_RISE !== mon_e.rise) begin
        fails++;
        $display("FAIL rise edge %0d: got %b expected %b", mon_e.edge_no, SW_RISE, mon_e.rise);
      end
      tests++;
      if (SW_FALL !== mon_e.fall) begin
        fails++;
        $display("FAIL fall edge %0d: got %b expected %b", mon_e.edge_no, SW_FALL, mon_e.fall);
      end
`ifdef SW_DEBOUNCE_TOGGLE_EN
      tests++;
      if (SW_TOGGLE !== mon_e.tog) begin
        fails++;
        $display("FAIL toggle edge %0d: got %b expected %b", mon_e.edge_no, SW_TOGGLE, mon_e.tog);
      end
`endif
    end
  end

  logic [NUM_SW-1:0] r;
  logic [NUM_SW-1:0] g;
  int                len;

  initial begin
    for (int ch = 0; ch < NUM_SW; ch++) last_evt[ch] = 0;

    // Reset held with switches high, then release: rise after 6 edges.
    hold(2'b11, 1'b1, 3);
    hold(2'b11, 1'b0, 8);
    // Fall on both channels simultaneously.
    hold(2'b00, 1'b0, 8);
    // Clean step on channel 0 only.
    hold(2'b01, 1'b0, 8);
    hold(2'b00, 1'b0, 8);
    // Bounce pattern on channel 0, then a solid hold.
    step(2'b01, 1'b0); step(2'b01, 1'b0); step(2'b01, 1'b0); step(2'b00, 1'b0);
    step(2'b01, 1'b0); step(2'b01, 1'b0); step(2'b00, 1'b0); step(2'b00, 1'b0);
    hold(2'b01, 1'b0, 8);
    // Glitch of exactly CNT_MAX-1 samples must be rejected.
    hold(2'b00, 1'b0, 3);
    hold(2'b01, 1'b0, 8);
    hold(2'b00, 1'b0, 8);
    // Reset in the middle of a pending count.
    hold(2'b01, 1'b0, 3);
    step(2'b01, 1'b1);
    hold(2'b01, 1'b0, 8);
    hold(2'b00, 1'b0, 8);
    // Three press/release cycles on channel 0.
    for (int p = 0; p < 3; p++) begin
      hold(2'b01, 1'b0, 8);
      hold(2'b00, 1'b0, 8);
    end

    // Randomised segments with occasional single-bit glitches and resets.
    for (int seg = 0; seg < 300; seg++) begin
      r   = NUM_SW'($urandom_range(0, 3));
      len = $urandom_range(1, 7);
      if ($urandom_range(0, 39) == 0) begin
        step(r, 1'b1);
      end else begin
        for (int c = 0; c < len; c++) begin
          g = '0;
          if ($urandom_range(0, 9) == 0) g[$urandom_range(0, NUM_SW - 1)] = 1'b1;
          step(r ^ g, 1'b0);
        end
      end
    end

    @(posedge CLK);
    #7;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard drain: got %0d pending entries, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
